// File: rtl/cpu_spm_portb_arbiter_if.sv
// Port-B bus bundle for the CPU scratch-pad RAM: two requesters (m0 = CPU
// MEM stage, m1 = bus-side agent) plus the RAM port B pins.
// The master modport is the outside world (requesters and RAM), the slave
// modport is the arbiter itself.
interface cpu_spm_portb_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  // m0: CPU MEM stage
  logic              m0_req;
  logic              m0_wr;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_rvalid;

  // m1: debug / DMA agent
  logic              m1_req;
  logic              m1_wr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_rvalid;

  // SPM port B
  logic [ADDR_W-1:0] spm_addrb;
  logic [DATA_W-1:0] spm_dinb;
  logic              spm_web;
  logic [DATA_W-1:0] spm_doutb;

  modport master (
    output m0_req, m0_wr, m0_addr, m0_wdata,
    input  m0_gnt, m0_rdata, m0_rvalid,
    output m1_req, m1_wr, m1_addr, m1_wdata,
    input  m1_gnt, m1_rdata, m1_rvalid,
    input  spm_addrb, spm_dinb, spm_web,
    output spm_doutb
  );

  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_wdata,
    output m0_gnt, m0_rdata, m0_rvalid,
    input  m1_req, m1_wr, m1_addr, m1_wdata,
    output m1_gnt, m1_rdata, m1_rvalid,
    output spm_addrb, spm_dinb, spm_web,
    input  spm_doutb
  );
endinterface

// File: rtl/cpu_spm_portb_arbiter.sv
// Port-B controller for the CPU scratch-pad dual-port RAM.
// After reset it optionally zero-fills the whole SPM (one word per cycle),
// then arbitrates port B between the CPU MEM stage (m0, high priority) and a
// bus-side agent (m1, low priority, force-granted after MAX_WAIT denials).
// Grants and the port-B address/data are combinational so a read granted in
// cycle N returns data in cycle N+1 from the registered RAM output.
module cpu_spm_portb_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4096,
  parameter int MAX_WAIT = 4,
  parameter int CLEAR_EN = 1
) (
  input  logic                    clk,
  input  logic                    reset,   // asynchronous, active-low
  cpu_spm_portb_arbiter_if.slave  spm_if,
  output logic                    busy
);

  localparam int WAIT_W = 4;
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_ARB   = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  localparam state_t ST_RESET = (CLEAR_EN != 0) ? ST_CLEAR : ST_ARB;

  // Registered state
  state_t            state_q,    state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  owner_t            rd_owner_q, rd_owner_d;
  // Last address/data driven on port B, held while nobody is granted
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [DATA_W-1:0] din_q,      din_d;

  // Combinational port-B drive before reset gating
  logic              m0_gnt_s;
  logic              m1_gnt_s;
  logic              web_s;
  logic [ADDR_W-1:0] addrb_s;
  logic [DATA_W-1:0] dinb_s;

  // State register plus clear pointer, starvation counter and read owner
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RESET;
      clr_addr_q <= '0;
      wait_cnt_q <= '0;
      rd_owner_q <= OWN_NONE;
      addr_q     <= '0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      wait_cnt_q <= wait_cnt_d;
      rd_owner_q <= rd_owner_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
    end
  end

  // Next-state, grant decision and port-B mux
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    wait_cnt_d = wait_cnt_q;
    rd_owner_d = OWN_NONE;
    m0_gnt_s   = 1'b0;
    m1_gnt_s   = 1'b0;
    web_s      = 1'b0;
    addrb_s    = addr_q;
    dinb_s     = din_q;

    case (state_q)
      ST_CLEAR: begin
        // Zero-fill sweep; requests are neither granted nor counted as waits.
        web_s      = 1'b1;
        addrb_s    = clr_addr_q;
        dinb_s     = '0;
        wait_cnt_d = '0;
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = ST_ARB;
          clr_addr_d = '0;
        end else begin
          state_d    = ST_CLEAR;
          clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
      end

      ST_ARB: begin
        // m1 overrides m0 only once it has been starved MAX_WAIT cycles.
        if (spm_if.m1_req && (wait_cnt_q == WAIT_MAX)) begin
          m1_gnt_s = 1'b1;
        end else if (spm_if.m0_req) begin
          m0_gnt_s = 1'b1;
        end else if (spm_if.m1_req) begin
          m1_gnt_s = 1'b1;
        end else begin
          m0_gnt_s = 1'b0;
          m1_gnt_s = 1'b0;
        end

        if (m0_gnt_s) begin
          web_s   = spm_if.m0_wr;
          addrb_s = spm_if.m0_addr;
          dinb_s  = spm_if.m0_wdata;
          rd_owner_d = spm_if.m0_wr ? OWN_NONE : OWN_M0;
        end else if (m1_gnt_s) begin
          web_s   = spm_if.m1_wr;
          addrb_s = spm_if.m1_addr;
          dinb_s  = spm_if.m1_wdata;
          rd_owner_d = spm_if.m1_wr ? OWN_NONE : OWN_M1;
        end else begin
          web_s      = 1'b0;
          rd_owner_d = OWN_NONE;
        end

        // Count consecutive denials of a pending m1 request, saturating.
        if (spm_if.m1_req && !m1_gnt_s) begin
          if (wait_cnt_q == WAIT_MAX) begin
            wait_cnt_d = WAIT_MAX;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else begin
          wait_cnt_d = '0;
        end
      end

      default: begin
        state_d    = ST_RESET;
        clr_addr_d = '0;
        wait_cnt_d = '0;
      end
    endcase

    addr_d = addrb_s;
    din_d  = dinb_s;
  end

  // Outputs are forced to their idle values for as long as reset is held,
  // so a write strobe or grant never leaks out while the block is in reset.
  assign spm_if.m0_gnt    = reset & m0_gnt_s;
  assign spm_if.m1_gnt    = reset & m1_gnt_s;
  assign spm_if.spm_web   = reset & web_s;
  assign spm_if.spm_addrb = reset ? addrb_s : '0;
  assign spm_if.spm_dinb  = reset ? dinb_s  : '0;

  // Read return: only the owner of last cycle's read sees the RAM data.
  assign spm_if.m0_rvalid = (rd_owner_q == OWN_M0);
  assign spm_if.m1_rvalid = (rd_owner_q == OWN_M1);
  assign spm_if.m0_rdata  = (rd_owner_q == OWN_M0) ? spm_if.spm_doutb : '0;
  assign spm_if.m1_rdata  = (rd_owner_q == OWN_M1) ? spm_if.spm_doutb : '0;

  assign busy = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_cpu_spm_portb_arbiter.sv
// Directed bench for cpu_spm_portb_arbiter: DEPTH=16, MAX_WAIT=4, CLEAR_EN=1.
// Inputs change at the falling edge; outputs are checked a couple of ns later.
module tb_cpu_spm_portb_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  cpu_spm_portb_arbiter_if #(.ADDR_W(12), .DATA_W(32)) spm_if ();

  cpu_spm_portb_arbiter #(
    .ADDR_W(12), .DATA_W(32), .DEPTH(16), .MAX_WAIT(4), .CLEAR_EN(1)
  ) u_dut (
    .clk(clk), .reset(reset), .spm_if(spm_if.slave), .busy(busy)
  );

  always #5 clk = ~clk;

  // Read-first RAM model for port B (registered output)
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    spm_if.spm_doutb <= mem[spm_if.spm_addrb];
    if (spm_if.spm_web) mem[spm_if.spm_addrb] <= spm_if.spm_dinb;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic req, input logic wr, input logic [11:0] a, input logic [31:0] d);
    spm_if.m0_req = req; spm_if.m0_wr = wr; spm_if.m0_addr = a; spm_if.m0_wdata = d;
  endtask

  task automatic drive_m1(input logic req, input logic wr, input logic [11:0] a, input logic [31:0] d);
    spm_if.m1_req = req; spm_if.m1_wr = wr; spm_if.m1_addr = a; spm_if.m1_wdata = d;
  endtask

  task automatic test_reset();
    step();
    checks++; if (spm_if.m0_gnt !== 1'b0) begin errors++; $display("FAIL rst_m0_gnt: got %0b want 0", spm_if.m0_gnt); end
    checks++; if (spm_if.m1_gnt !== 1'b0) begin errors++; $display("FAIL rst_m1_gnt: got %0b want 0", spm_if.m1_gnt); end
    checks++; if (spm_if.spm_web !== 1'b0) begin errors++; $display("FAIL rst_web: got %0b want 0", spm_if.spm_web); end
    checks++; if (spm_if.spm_addrb !== 12'h000) begin errors++; $display("FAIL rst_addrb: got %h want 000", spm_if.spm_addrb); end
    checks++; if (spm_if.spm_dinb !== 32'h0) begin errors++; $display("FAIL rst_dinb: got %h want 0", spm_if.spm_dinb); end
    checks++; if ({spm_if.m0_rvalid, spm_if.m1_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %b want 00", {spm_if.m0_rvalid, spm_if.m1_rvalid}); end
    checks++; if ({spm_if.m0_rdata, spm_if.m1_rdata} !== 64'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", {spm_if.m0_rdata, spm_if.m1_rdata}); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %0b want 1", busy); end
  endtask

  // Zero-fill sweep; an m0 write raised in sweep cycle 5 waits for ARB.
  task automatic test_clear();
    step();
    reset = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        drive_m0(1'b1, 1'b1, 12'h030, 32'hA5A5A5A5);
        #1;
      end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy[%0d]: got %0b want 1", i, busy); end
      checks++; if (spm_if.spm_web !== 1'b1) begin errors++; $display("FAIL clr_web[%0d]: got %0b want 1", i, spm_if.spm_web); end
      checks++; if (spm_if.spm_addrb !== 12'(i)) begin errors++; $display("FAIL clr_addrb[%0d]: got %h want %h", i, spm_if.spm_addrb, 12'(i)); end
      checks++; if (spm_if.spm_dinb !== 32'h0) begin errors++; $display("FAIL clr_dinb[%0d]: got %h want 0", i, spm_if.spm_dinb); end
      checks++; if (spm_if.m0_gnt !== 1'b0) begin errors++; $display("FAIL clr_m0_gnt[%0d]: got %0b want 0", i, spm_if.m0_gnt); end
      step();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_done_busy: got %0b want 0", busy); end
    checks++; if (spm_if.m0_gnt !== 1'b1) begin errors++; $display("FAIL clr_done_m0_gnt: got %0b want 1", spm_if.m0_gnt); end
    checks++; if (spm_if.spm_addrb !== 12'h030) begin errors++; $display("FAIL clr_done_addrb: got %h want 030", spm_if.spm_addrb); end
    step();
    drive_m0(1'b0, 1'b0, 12'h000, 32'h0);
  endtask

  task automatic test_write_read();
    step();
    drive_m0(1'b1, 1'b1, 12'h010, 32'hDEADBEEF);
    #1;
    checks++; if (spm_if.m0_gnt !== 1'b1) begin errors++; $display("FAIL wr_m0_gnt: got %0b want 1", spm_if.m0_gnt); end
    checks++; if (spm_if.spm_web !== 1'b1) begin errors++; $display("FAIL wr_web: got %0b want 1", spm_if.spm_web); end
    checks++; if (spm_if.spm_dinb !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_dinb: got %h want deadbeef", spm_if.spm_dinb); end
    step();
    drive_m0(1'b1, 1'b0, 12'h010, 32'h0);
    #1;
    checks++; if (spm_if.m0_gnt !== 1'b1) begin errors++; $display("FAIL rd_m0_gnt: got %0b want 1", spm_if.m0_gnt); end
    checks++; if (spm_if.spm_web !== 1'b0) begin errors++; $display("FAIL rd_web: got %0b want 0", spm_if.spm_web); end
    checks++; if (spm_if.m0_rvalid !== 1'b0) begin errors++; $display("FAIL rd_early_rvalid: got %0b want 0", spm_if.m0_rvalid); end
    step();
    drive_m0(1'b0, 1'b0, 12'h000, 32'h0);
    #1;
    checks++; if (spm_if.m0_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid: got %0b want 1", spm_if.m0_rvalid); end
    checks++; if (spm_if.m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata: got %h want deadbeef", spm_if.m0_rdata); end
    checks++; if (spm_if.m1_rvalid !== 1'b0) begin errors++; $display("FAIL rd_m1_rvalid: got %0b want 0", spm_if.m1_rvalid); end
    checks++; if (spm_if.m1_rdata !== 32'h0) begin errors++; $display("FAIL rd_m1_rdata: got %h want 0", spm_if.m1_rdata); end
    step();
    checks++; if (spm_if.m0_rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_drop: got %0b want 0", spm_if.m0_rvalid); end
    checks++; if (spm_if.m0_rdata !== 32'h0) begin errors++; $display("FAIL rd_rdata_zero: got %h want 0", spm_if.m0_rdata); end
    checks++; if (spm_if.spm_addrb !== 12'h010) begin errors++; $display("FAIL idle_addr_hold: got %h want 010", spm_if.spm_addrb); end
    checks++; if (spm_if.spm_web !== 1'b0) begin errors++; $display("FAIL idle_web: got %0b want 0", spm_if.spm_web); end
  endtask

  // Both requesting continuously: m0,m0,m0,m0,m1 repeating.
  task automatic test_priority();
    logic exp_m1;
    step();
    drive_m0(1'b1, 1'b0, 12'h000, 32'h0);
    drive_m1(1'b1, 1'b0, 12'h000, 32'h0);
    #1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      exp_m1 = (i == 4) || (i == 9);
      checks++; if (spm_if.m1_gnt !== exp_m1) begin errors++; $display("FAIL prio_m1_gnt[%0d]: got %0b want %0b", i, spm_if.m1_gnt, exp_m1); end
      checks++; if (spm_if.m0_gnt !== !exp_m1) begin errors++; $display("FAIL prio_m0_gnt[%0d]: got %0b want %0b", i, spm_if.m0_gnt, !exp_m1); end
    end
    step();
    drive_m0(1'b0, 1'b0, 12'h000, 32'h0);
    drive_m1(1'b0, 1'b0, 12'h000, 32'h0);
    step();
  endtask

  task automatic test_alternating();
    step();
    drive_m0(1'b1, 1'b1, 12'h001, 32'h11111111);
    #1;
    checks++; if (spm_if.m0_gnt !== 1'b1) begin errors++; $display("FAIL alt_wr0_gnt: got %0b want 1", spm_if.m0_gnt); end
    step();
    drive_m0(1'b0, 1'b0, 12'h000, 32'h0);
    drive_m1(1'b1, 1'b1, 12'h002, 32'h22222222);
    #1;
    checks++; if (spm_if.m1_gnt !== 1'b1) begin errors++; $display("FAIL alt_wr1_gnt: got %0b want 1", spm_if.m1_gnt); end
    checks++; if (spm_if.spm_addrb !== 12'h002) begin errors++; $display("FAIL alt_wr1_addrb: got %h want 002", spm_if.spm_addrb); end
    checks++; if (spm_if.spm_dinb !== 32'h22222222) begin errors++; $display("FAIL alt_wr1_dinb: got %h want 22222222", spm_if.spm_dinb); end
    step();
    drive_m1(1'b0, 1'b0, 12'h000, 32'h0);
    drive_m0(1'b1, 1'b0, 12'h001, 32'h0);
    #1;
    checks++; if (spm_if.m0_gnt !== 1'b1) begin errors++; $display("FAIL alt_rd0_gnt: got %0b want 1", spm_if.m0_gnt); end
    step();
    drive_m0(1'b0, 1'b0, 12'h000, 32'h0);
    drive_m1(1'b1, 1'b0, 12'h002, 32'h0);
    #1;
    checks++; if (spm_if.m1_gnt !== 1'b1) begin errors++; $display("FAIL alt_rd1_gnt: got %0b want 1", spm_if.m1_gnt); end
    checks++; if ({spm_if.m0_rvalid, spm_if.m1_rvalid} !== 2'b10) begin errors++; $display("FAIL alt_rv_a: got %b want 10", {spm_if.m0_rvalid, spm_if.m1_rvalid}); end
    checks++; if (spm_if.m0_rdata !== 32'h11111111) begin errors++; $display("FAIL alt_m0_data_a: got %h want 11111111", spm_if.m0_rdata); end
    checks++; if (spm_if.m1_rdata !== 32'h0) begin errors++; $display("FAIL alt_m1_zero_a: got %h want 0", spm_if.m1_rdata); end
    step();
    drive_m1(1'b0, 1'b0, 12'h000, 32'h0);
    drive_m0(1'b1, 1'b0, 12'h001, 32'h0);
    #1;
    checks++; if ({spm_if.m0_rvalid, spm_if.m1_rvalid} !== 2'b01) begin errors++; $display("FAIL alt_rv_b: got %b want 01", {spm_if.m0_rvalid, spm_if.m1_rvalid}); end
    checks++; if (spm_if.m1_rdata !== 32'h22222222) begin errors++; $display("FAIL alt_m1_data_b: got %h want 22222222", spm_if.m1_rdata); end
    checks++; if (spm_if.m0_rdata !== 32'h0) begin errors++; $display("FAIL alt_m0_zero_b: got %h want 0", spm_if.m0_rdata); end
    step();
    drive_m0(1'b0, 1'b0, 12'h000, 32'h0);
    #1;
    checks++; if ({spm_if.m0_rvalid, spm_if.m1_rvalid} !== 2'b10) begin errors++; $display("FAIL alt_rv_c: got %b want 10", {spm_if.m0_rvalid, spm_if.m1_rvalid}); end
    checks++; if (spm_if.m0_rdata !== 32'h11111111) begin errors++; $display("FAIL alt_m0_data_c: got %h want 11111111", spm_if.m0_rdata); end
    step();
    checks++; if ({spm_if.m0_rvalid, spm_if.m1_rvalid} !== 2'b00) begin errors++; $display("FAIL alt_rv_d: got %b want 00", {spm_if.m0_rvalid, spm_if.m1_rvalid}); end
  endtask

  // m1 alone: granted at once, back-to-back reads give one rvalid per cycle.
  task automatic test_m1_only();
    step();
    drive_m1(1'b1, 1'b0, 12'h002, 32'h0);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      checks++; if (spm_if.m1_gnt !== 1'b1) begin errors++; $display("FAIL m1only_gnt[%0d]: got %0b want 1", i, spm_if.m1_gnt); end
      checks++; if (spm_if.m0_gnt !== 1'b0) begin errors++; $display("FAIL m1only_m0_gnt[%0d]: got %0b want 0", i, spm_if.m0_gnt); end
      if (i > 0) begin
        checks++; if (spm_if.m1_rvalid !== 1'b1) begin errors++; $display("FAIL m1only_rvalid[%0d]: got %0b want 1", i, spm_if.m1_rvalid); end
        checks++; if (spm_if.m1_rdata !== 32'h22222222) begin errors++; $display("FAIL m1only_rdata[%0d]: got %h want 22222222", i, spm_if.m1_rdata); end
      end
    end
    // Raise m0 too: m1 was never denied, so m0 must win four times first.
    step();
    drive_m0(1'b1, 1'b0, 12'h000, 32'h0);
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      checks++; if (spm_if.m1_gnt !== (i == 4)) begin errors++; $display("FAIL m1only_wait[%0d]: got %0b want %0b", i, spm_if.m1_gnt, (i == 4)); end
    end
    step();
    drive_m0(1'b0, 1'b0, 12'h000, 32'h0);
    drive_m1(1'b0, 1'b0, 12'h000, 32'h0);
    step();
  endtask

  task automatic test_reset_mid();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    for (int i = 0; i < 7; i++) step();
    checks++; if (spm_if.spm_addrb !== 12'h007) begin errors++; $display("FAIL mid_addr7: got %h want 007", spm_if.spm_addrb); end
    reset = 1'b0;
    #1;
    checks++; if (spm_if.spm_web !== 1'b0) begin errors++; $display("FAIL mid_clr_web: got %0b want 0", spm_if.spm_web); end
    checks++; if (spm_if.spm_addrb !== 12'h000) begin errors++; $display("FAIL mid_clr_addrb: got %h want 000", spm_if.spm_addrb); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_clr_busy: got %0b want 1", busy); end
    step();
    reset = 1'b1;
    #1;
    checks++; if (spm_if.spm_addrb !== 12'h000 || spm_if.spm_web !== 1'b1) begin errors++; $display("FAIL mid_restart: got addr %h web %0b want 000 1", spm_if.spm_addrb, spm_if.spm_web); end
    step();
    checks++; if (spm_if.spm_addrb !== 12'h001) begin errors++; $display("FAIL mid_restart_next: got %h want 001", spm_if.spm_addrb); end
    for (int i = 0; i < 15; i++) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_clr_done: got %0b want 0", busy); end
    // Outstanding m1 read cut by reset before its data phase.
    drive_m1(1'b1, 1'b0, 12'h002, 32'h0);
    #1;
    checks++; if (spm_if.m1_gnt !== 1'b1) begin errors++; $display("FAIL mid_rd_gnt: got %0b want 1", spm_if.m1_gnt); end
    reset = 1'b0;
    #1;
    checks++; if (spm_if.m1_gnt !== 1'b0) begin errors++; $display("FAIL mid_rd_gnt_drop: got %0b want 0", spm_if.m1_gnt); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (spm_if.m1_rvalid !== 1'b0 || spm_if.m1_rdata !== 32'h0) begin errors++; $display("FAIL mid_rd_rvalid[%0d]: got %0b/%h want 0/0", i, spm_if.m1_rvalid, spm_if.m1_rdata); end
    end
    step();
    drive_m1(1'b0, 1'b0, 12'h000, 32'h0);
    reset = 1'b1;
    #1;
    checks++; if (spm_if.m1_rvalid !== 1'b0) begin errors++; $display("FAIL mid_rd_after: got %0b want 0", spm_if.m1_rvalid); end
    checks++; if (busy !== 1'b1 || spm_if.spm_addrb !== 12'h000) begin errors++; $display("FAIL mid_rd_restart: got busy %0b addr %h want 1 000", busy, spm_if.spm_addrb); end
  endtask

  initial begin
    reset = 1'b0;
    drive_m0(1'b0, 1'b0, 12'h000, 32'h0);
    drive_m1(1'b0, 1'b0, 12'h000, 32'h0);
    test_reset();
    test_clear();
    test_write_read();
    test_priority();
    test_alternating();
    test_m1_only();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_spm_portb_arbiter.md
Name: cpu_spm_portb_arbiter

Overview:
- Controller for port B of the CPU scratch-pad dual-port RAM.
- After reset it optionally zero-fills the whole SPM. It then shares port B between two requesters:
  - m0: CPU MEM stage, high priority.
  - m1: bus-side agent (debug/DMA), low priority with an anti-starvation guarantee.
- Port A stays dedicated to instruction fetch and is not touched by this block.

Parameters:
ADDR_W, 12, SPM word-address width
DATA_W, 32, word data width
DEPTH, 4096, SPM words; clear sweep covers 0..DEPTH-1
MAX_WAIT, 4, consecutive cycles m1 may be denied before it is force-granted (1..15)
CLEAR_EN, 1, 1 = zero-fill SPM after reset; 0 = go directly to ARB

Ports:
clk  in  1  system clock; SPM port B runs on the same clock
reset  in  1  asynchronous, active-low reset
m0_req  in  1  CPU access request
m0_wr  in  1  1 = write, 0 = read
m0_addr  in  ADDR_W  word address
m0_wdata  in  DATA_W  write data
m0_gnt  out  1  access accepted this cycle (combinational)
m0_rdata  out  DATA_W  read data
m0_rvalid  out  1  m0_rdata valid
m1_req, m1_wr, m1_addr, m1_wdata  in  1/1/ADDR_W/DATA_W  same as m0
m1_gnt, m1_rdata, m1_rvalid  out  1/DATA_W/1  same as m0
spm_addrb  out  ADDR_W  RAM port B address
spm_dinb  out  DATA_W  RAM port B write data
spm_web  out  1  RAM port B write enable
spm_doutb  in  DATA_W  RAM port B read data, registered, 1-cycle latency
busy  out  1  high while CLEAR is in progress

Behaviour:
- Reset (async, reset=0), all outputs and registers forced to:
  - state = CLEAR if CLEAR_EN, else ARB;
  - clr_addr = 0, wait_cnt = 0, rd_owner = none;
  - gnt/rvalid = 0, spm_web = 0, spm_addrb/spm_dinb = 0, rdata = 0;
  - busy = CLEAR_EN.
- State CLEAR:
  - spm_web = 1, spm_addrb = clr_addr, spm_dinb = 0.
  - clr_addr increments every cycle.
  - When clr_addr == DEPTH-1 is written, next state = ARB, busy drops on that edge.
  - Takes exactly DEPTH cycles. Both gnt = 0; requests are ignored, not queued.
- State ARB, grant rule (combinational from req and wait_cnt):
  - If m1_req and wait_cnt == MAX_WAIT, then m1_gnt = 1, even if m0_req is high.
  - Else if m0_req, then m0_gnt = 1.
  - Else if m1_req, then m1_gnt = 1.
  - At most one gnt per cycle.
- Muxing: the granted requester's addr/wdata drive spm_addrb/spm_dinb, and spm_web = its wr. With no grant, spm_web = 0 and addr/din hold their last value.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) when m1_req=1 and m1_gnt=0.
  - Clears to 0 when m1_gnt=1 or m1_req=0.
- Read return:
  - A granted read sets rd_owner to the granted master; writes and idle cycles set none.
  - Next cycle: that master's rvalid = 1 and rdata = spm_doutb. The other master's rdata = 0 and rvalid = 0.
  - rdata returns to 0 when rvalid = 0.
  - Latency is request-to-data 1 cycle; back-to-back reads give one rvalid per cycle.
- Read-during-write: same-address same-port write returns old data (RAM read-first). The arbiter does no forwarding.
- A requester must hold req/addr/wr/wdata stable until it sees gnt. A request is consumed in the gnt cycle.
- Reset asserted mid-CLEAR or mid-read: everything returns to reset values immediately. A pending rvalid is dropped, and CLEAR restarts from address 0.

Test Plan:
- CLEAR_EN=1, DEPTH=16: release reset → busy=1 for 16 cycles, spm_web=1 with addrb 0..15 and dinb=0, then busy=0. A m0_req at cycle 5 gets no gnt until ARB.
- ARB: m0 write addr 0x010 data 0xDEADBEEF, then m0 read 0x010 → m0_gnt each cycle; m0_rvalid=1 with m0_rdata=0xDEADBEEF one cycle after the read grant; m1_rvalid stays 0.
- m0_req and m1_req held high continuously, MAX_WAIT=4 → grant pattern m0,m0,m0,m0,m1 repeating; wait_cnt resets after each m1 grant.
- Alternating reads m0@0x001 (0x11111111), m1@0x002 (0x22222222) in consecutive cycles → rvalid alternates m0,m1, each with the correct data, no cross-contamination.
- Only m1 requesting → m1_gnt same cycle, wait_cnt stays 0; m1 read data valid next cycle.
- Reset pulse during CLEAR at clr_addr=7 and during an outstanding m1 read → all outputs 0 immediately; m1_rvalid never asserts; CLEAR restarts at address 0.
